// File: rtl/tinynpu_pkg.sv
// Shared types and sizing helpers for the TinyNPU output drain.
package tinynpu_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_t;

  function automatic int acc_bits(input int size, input int nbits);
    return 2 * nbits + $clog2(size);
  endfunction

endpackage

// File: rtl/tinynpu_out_drain_if.sv
// Array-side vector handshake and host-side serial beat handshake of the output drain.
interface tinynpu_out_drain_if
  import tinynpu_pkg::*;
#(
  parameter int SIZE  = 4,
  parameter int NBITS = 8,
  parameter int ABITS = acc_bits(SIZE, NBITS)
);
  localparam int SW = $clog2(ABITS);
  localparam int CW = $clog2(SIZE);

  logic                    acc_val;
  logic                    acc_rdy;
  logic signed [ABITS-1:0] acc_in [SIZE];
  logic [SW-1:0]           shift;
  logic                    relu_en;
  logic                    out_val;
  logic                    out_rdy;
  logic [NBITS-1:0]        out_data;
  logic [CW-1:0]           out_sel;
  logic                    out_last;

  modport master (
    output acc_val, acc_in, shift, relu_en, out_rdy,
    input  acc_rdy, out_val, out_data, out_sel, out_last
  );

  modport slave (
    input  acc_val, acc_in, shift, relu_en, out_rdy,
    output acc_rdy, out_val, out_data, out_sel, out_last
  );

endinterface

// File: rtl/tinynpu_requant.sv
// Combinational requantizer: arithmetic right shift, optional ReLU, saturate to NBITS signed.
module tinynpu_requant #(
  parameter int ABITS = 18,
  parameter int NBITS = 8
) (
  input  logic signed [ABITS-1:0]         i_acc,
  input  logic [$clog2(ABITS)-1:0]        i_shift,
  input  logic                            i_relu_en,
  output logic [NBITS-1:0]                o_q
);
  localparam logic signed [ABITS-1:0] Q_MAX = ABITS'((2 ** (NBITS - 1)) - 1);
  localparam logic signed [ABITS-1:0] Q_MIN = ABITS'(-(2 ** (NBITS - 1)));

  logic signed [ABITS-1:0] w_shr;
  logic signed [ABITS-1:0] w_relu;

  always_comb begin
    // Oversized shifts collapse to the sign fill (0 or -1).
    if (32'(i_shift) >= ABITS) w_shr = {ABITS{i_acc[ABITS-1]}};
    else                       w_shr = i_acc >>> i_shift;

    w_relu = (i_relu_en && w_shr[ABITS-1]) ? '0 : w_shr;

    if (w_relu > Q_MAX)      o_q = Q_MAX[NBITS-1:0];
    else if (w_relu < Q_MIN) o_q = Q_MIN[NBITS-1:0];
    else                     o_q = w_relu[NBITS-1:0];
  end

endmodule

// File: rtl/tinynpu_out_drain.sv
// Captures one accumulator row and drains it to the host one requantized column per beat.
// state | meaning
// IDLE  | waiting for an accumulator vector, acc_rdy=1
// DRAIN | presenting column r_col to the host, out_val=1
module tinynpu_out_drain
  import tinynpu_pkg::*;
#(
  parameter int SIZE  = 4,
  parameter int NBITS = 8,
  parameter int ABITS = acc_bits(SIZE, NBITS)
) (
  input  logic                clk,
  input  logic                rst,
  tinynpu_out_drain_if.slave  bus
);
  localparam int CW = $clog2(SIZE);
  localparam int SW = $clog2(ABITS);

  drain_state_t            r_state, w_state_nxt;
  logic [CW-1:0]           r_col, w_col_nxt;
  logic signed [ABITS-1:0] r_acc [SIZE];
  logic [SW-1:0]           r_shift;
  logic                    r_relu;

  logic                    w_last;
  logic                    w_acc_rdy;
  logic                    w_cap;
  logic [NBITS-1:0]        w_q;

  assign w_last = (r_col == CW'(SIZE - 1));
  // Last beat accepted frees the capture regs in the same cycle: no bubble between vectors.
  assign w_acc_rdy = (r_state == IDLE) || (w_last && bus.out_rdy);
  assign w_cap     = bus.acc_val && w_acc_rdy;

  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    case (r_state)
      IDLE: begin
        if (w_cap) begin
          w_state_nxt = DRAIN;
          w_col_nxt   = '0;
        end
      end
      DRAIN: begin
        if (bus.out_rdy) begin
          if (w_last) begin
            w_state_nxt = w_cap ? DRAIN : IDLE;
            w_col_nxt   = '0;
          end else begin
            w_col_nxt = r_col + CW'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_col   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_col   <= w_col_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SIZE; i++) r_acc[i] <= '0;
      r_shift <= '0;
      r_relu  <= 1'b0;
    end else if (w_cap) begin
      for (int i = 0; i < SIZE; i++) r_acc[i] <= bus.acc_in[i];
      r_shift <= bus.shift;
      r_relu  <= bus.relu_en;
    end
  end

  tinynpu_requant #(
    .ABITS (ABITS),
    .NBITS (NBITS)
  ) u_requant (
    .i_acc     (r_acc[r_col]),
    .i_shift   (r_shift),
    .i_relu_en (r_relu),
    .o_q       (w_q)
  );

  assign bus.acc_rdy  = w_acc_rdy;
  assign bus.out_val  = (r_state == DRAIN);
  assign bus.out_sel  = (r_state == DRAIN) ? r_col : '0;
  assign bus.out_data = (r_state == DRAIN) ? w_q : '0;
  assign bus.out_last = (r_state == DRAIN) && w_last;

endmodule

// File: tb/tb_tinynpu_out_drain.sv
// Directed bench for tinynpu_out_drain with hand-computed expected beats.
module tb_tinynpu_out_drain;
  localparam int SIZE  = 4;
  localparam int NBITS = 8;
  localparam int ABITS = 18;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  tinynpu_out_drain_if #(.SIZE(SIZE), .NBITS(NBITS), .ABITS(ABITS)) bus ();

  tinynpu_out_drain #(.SIZE(SIZE), .NBITS(NBITS), .ABITS(ABITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_vec(input int a0, input int a1, input int a2, input int a3);
    bus.acc_in[0] = ABITS'(a0);
    bus.acc_in[1] = ABITS'(a1);
    bus.acc_in[2] = ABITS'(a2);
    bus.acc_in[3] = ABITS'(a3);
  endtask

  // Called at a negedge while IDLE; returns at the negedge of the first beat.
  task automatic send_vec(input string tag, input int a0, input int a1, input int a2,
                          input int a3, input int sh, input logic relu);
    set_vec(a0, a1, a2, a3);
    bus.shift   = 5'(sh);
    bus.relu_en = relu;
    bus.acc_val = 1'b1;
    #1;
    chk({tag, "_cap_rdy"}, bus.acc_rdy, 1);
    chk({tag, "_cap_val"}, bus.out_val, 0);
    @(negedge clk);
    bus.acc_val = 1'b0;
  endtask

  // e packs the expected beats as {b3, b2, b1, b0}; out_rdy is assumed high.
  task automatic expect_beats(input string tag, input logic [31:0] e);
    for (int i = 0; i < SIZE; i++) begin
      #1;
      chk({tag, "_val"},  bus.out_val, 1);
      chk({tag, "_sel"},  bus.out_sel, i);
      chk({tag, "_data"}, bus.out_data, e[8*i +: 8]);
      chk({tag, "_last"}, bus.out_last, (i == SIZE - 1));
      chk({tag, "_rdy"},  bus.acc_rdy, (i == SIZE - 1));
      @(negedge clk);
    end
  endtask

  task automatic expect_idle(input string tag);
    #1;
    chk({tag, "_idle_val"}, bus.out_val, 0);
    chk({tag, "_idle_rdy"}, bus.acc_rdy, 1);
    @(negedge clk);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst         = 1'b0;
    bus.acc_val = 1'b0;
    bus.out_rdy = 1'b1;
    bus.shift   = '0;
    bus.relu_en = 1'b0;
    set_vec(0, 0, 0, 0);

    #1;
    chk("rst_val",  bus.out_val, 0);
    chk("rst_rdy",  bus.acc_rdy, 1);
    chk("rst_sel",  bus.out_sel, 0);
    chk("rst_last", bus.out_last, 0);
    chk("rst_data", bus.out_data, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    send_vec("basic", 10, 20, -30, 40, 0, 1'b0);
    expect_beats("basic", {8'd40, 8'hE2, 8'd20, 8'd10});
    expect_idle("basic");

    send_vec("sat0", 300, -300, 127, -128, 0, 1'b0);
    expect_beats("sat0", {8'h80, 8'h7F, 8'h80, 8'h7F});
    send_vec("sh2", 300, -300, 127, -128, 2, 1'b0);
    expect_beats("sh2", {8'hE0, 8'h1F, 8'hB5, 8'h4B});
    send_vec("sh20", -1, 5, -1000, 1000, 20, 1'b0);
    expect_beats("sh20", {8'h00, 8'hFF, 8'h00, 8'hFF});
    send_vec("sh1", -3, 3, 256, -257, 1, 1'b0);
    expect_beats("sh1", {8'h80, 8'h7F, 8'h01, 8'hFE});

    // Settings change right after capture must not affect the vector in flight.
    send_vec("relu", -5, 5, -1, 0, 0, 1'b1);
    bus.relu_en = 1'b0;
    bus.shift   = 5'd3;
    expect_beats("relu", {8'h00, 8'h00, 8'h05, 8'h00});
    expect_idle("relu");

    send_vec("bp", 10, 20, -30, 40, 0, 1'b0);
    #1;
    chk("bp_b0_data", bus.out_data, 8'd10);
    @(negedge clk);
    bus.out_rdy = 1'b0;
    set_vec(99, 98, 97, 96);
    bus.acc_val = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_hold_val",  bus.out_val, 1);
      chk("bp_hold_data", bus.out_data, 8'd20);
      chk("bp_hold_sel",  bus.out_sel, 1);
      chk("bp_hold_last", bus.out_last, 0);
      chk("bp_hold_rdy",  bus.acc_rdy, 0);
      @(negedge clk);
    end
    bus.acc_val = 1'b0;
    bus.out_rdy = 1'b1;
    #1;
    chk("bp_b1_data", bus.out_data, 8'd20);
    @(negedge clk);
    #1;
    chk("bp_b2_data", bus.out_data, 8'hE2);
    chk("bp_b2_sel",  bus.out_sel, 2);
    @(negedge clk);
    #1;
    chk("bp_b3_data", bus.out_data, 8'd40);
    chk("bp_b3_last", bus.out_last, 1);
    @(negedge clk);
    expect_idle("bp");

    set_vec(10, 20, -30, 40);
    bus.shift   = '0;
    bus.relu_en = 1'b0;
    bus.acc_val = 1'b1;
    #1;
    chk("b2b_cap_rdy", bus.acc_rdy, 1);
    @(negedge clk);
    set_vec(1, 2, 3, 4);
    expect_beats("b2b_a", {8'd40, 8'hE2, 8'd20, 8'd10});
    bus.acc_val = 1'b0;
    expect_beats("b2b_b", {8'd4, 8'd3, 8'd2, 8'd1});
    expect_idle("b2b");

    send_vec("ar", 10, 20, -30, 40, 0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("ar_pre_sel", bus.out_sel, 2);
    #1;
    rst = 1'b0;
    #1;
    chk("ar_val",  bus.out_val, 0);
    chk("ar_rdy",  bus.acc_rdy, 1);
    chk("ar_sel",  bus.out_sel, 0);
    chk("ar_data", bus.out_data, 0);
    #1;
    rst = 1'b1;
    @(negedge clk);
    expect_idle("ar_post");
    send_vec("ar_next", 7, 8, 9, 10, 0, 1'b0);
    expect_beats("ar_next", {8'd10, 8'd9, 8'd8, 8'd7});
    expect_idle("ar_next");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
